// File: rtl/instr_dispatch_controller_pkg.sv
// Shared types, opcode constants and instruction field offsets for the dispatch stage.
// Instruction layout, MSB..LSB: {op_type[1:0], opcode, rd, rs1, rs2, pc, imm}.
package instr_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        TRAP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    localparam int unsigned ADD = 0;
    localparam int unsigned MUL = 1;
    localparam int unsigned DIV = 2;
    localparam int unsigned CMP = 3;

    function automatic int instr_width(int opw, int aw, int pcw, int dw);
        return 2 + opw + 3 * aw + pcw + dw;
    endfunction

    // imm always sits at bit 0; every other field is stacked above it
    function automatic int pc_lsb(int dw);
        return dw;
    endfunction

    function automatic int rs2_lsb(int dw, int pcw);
        return dw + pcw;
    endfunction

    function automatic int rs1_lsb(int dw, int pcw, int aw);
        return dw + pcw + aw;
    endfunction

    function automatic int rd_lsb(int dw, int pcw, int aw);
        return dw + pcw + 2 * aw;
    endfunction

    function automatic int opcode_lsb(int dw, int pcw, int aw);
        return dw + pcw + 3 * aw;
    endfunction

    function automatic int optype_lsb(int dw, int pcw, int aw, int opw);
        return dw + pcw + 3 * aw + opw;
    endfunction

endpackage

// File: rtl/instr_dispatch_controller_if.sv
// CPU-side request/completion handshake plus the per-unit start/busy/done bus and broadcast fields.
// master = CPU and execution units, slave = the dispatch controller.
interface instr_dispatch_controller_if
    import instr_dispatch_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int PCW       = 5,
    parameter int OPW       = 5,
    parameter int NUM_UNITS = 4
);
    localparam int IW = instr_width(OPW, AW, PCW, DW);

    logic                     start;
    logic [IW-1:0]            instr;
    logic                     busy;
    logic                     done;
    logic                     fetch_en;
    logic                     error;
    logic [1:0]               err_code;
    logic [PCW-1:0]           next_pc;

    logic [NUM_UNITS-1:0]     unit_start;
    logic [NUM_UNITS-1:0]     unit_busy;
    logic [NUM_UNITS-1:0]     unit_done;
    logic [NUM_UNITS*PCW-1:0] unit_next_pc;

    logic [1:0]               op_type;
    logic [AW-1:0]            src1_addr;
    logic [AW-1:0]            src2_addr;
    logic [AW-1:0]            dst_addr;
    logic [PCW-1:0]           pc;
    logic [DW-1:0]            imm;

    modport master (
        output start, instr, unit_busy, unit_done, unit_next_pc,
        input  busy, done, fetch_en, error, err_code, next_pc, unit_start,
        input  op_type, src1_addr, src2_addr, dst_addr, pc, imm
    );

    modport slave (
        input  start, instr, unit_busy, unit_done, unit_next_pc,
        output busy, done, fetch_en, error, err_code, next_pc, unit_start,
        output op_type, src1_addr, src2_addr, dst_addr, pc, imm
    );

endinterface

// File: rtl/instr_dispatch_controller_watchdog.sv
// Cycle counter for the ISSUE+WAIT window; expired holds once the count reaches TIMEOUT.
module dispatch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT));

    // Saturate so the count can never wrap back below TIMEOUT
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_dispatch_controller.sv
// Decode/dispatch stage: latches one instruction, routes it to the unit named by its opcode,
// runs the start/busy/done handshake and reports completion, traps and timeouts to the CPU.
module instr_dispatch_controller
    import instr_dispatch_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int PCW       = 5,
    parameter int OPW       = 5,
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_dispatch_controller_if.slave bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_TRAP  = TRAP;

    localparam int SELW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int PC_LSB  = pc_lsb(DW);
    localparam int RS2_LSB = rs2_lsb(DW, PCW);
    localparam int RS1_LSB = rs1_lsb(DW, PCW, AW);
    localparam int RD_LSB  = rd_lsb(DW, PCW, AW);
    localparam int OPC_LSB = opcode_lsb(DW, PCW, AW);
    localparam int OPT_LSB = optype_lsb(DW, PCW, AW, OPW);

    logic [1:0]           state_q, state_d;
    logic [SELW-1:0]      sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [PCW-1:0]       next_pc_q, next_pc_d;
    logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
    logic [1:0]           op_type_q, op_type_d;
    logic [AW-1:0]        src1_q, src1_d;
    logic [AW-1:0]        src2_q, src2_d;
    logic [AW-1:0]        dst_q, dst_d;
    logic [PCW-1:0]       pc_q, pc_d;
    logic [DW-1:0]        imm_q, imm_d;

    logic [OPW-1:0]       opcode;
    logic                 legal;
    logic                 sel_busy;
    logic                 sel_done;
    logic [PCW-1:0]       sel_npc;
    logic [NUM_UNITS-1:0] sel_onehot;
    logic [PCW-1:0]       pc_inc;
    logic                 wd_clr;
    logic                 wd_en;
    logic                 wd_expired;
    logic                 timeout;

    assign opcode   = bus.instr[OPC_LSB +: OPW];
    assign legal    = (int'(opcode) < NUM_UNITS);
    assign sel_busy = bus.unit_busy[sel_q];
    assign sel_done = bus.unit_done[sel_q];
    assign sel_npc  = bus.unit_next_pc[int'(sel_q) * PCW +: PCW];
    assign pc_inc   = pc_q + PCW'(1);

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[sel_q] = 1'b1;
    end

    dispatch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        next_pc_d    = next_pc_q;
        unit_start_d = unit_start_q;
        op_type_d    = op_type_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        dst_d        = dst_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;
        timeout      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_type_d  = bus.instr[OPT_LSB +: 2];
                    dst_d      = bus.instr[RD_LSB +: AW];
                    src1_d     = bus.instr[RS1_LSB +: AW];
                    src2_d     = bus.instr[RS2_LSB +: AW];
                    pc_d       = bus.instr[PC_LSB +: PCW];
                    imm_d      = bus.instr[0 +: DW];
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    if (legal) begin
                        sel_d   = SELW'(opcode);
                        wd_clr  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_TRAP;
                    end
                end
            end
            S_ISSUE: begin
                wd_en = 1'b1;
                if (wd_expired) begin
                    timeout = 1'b1;
                end else if (sel_busy) begin
                    unit_start_d = '0;
                    state_d      = S_WAIT;
                end else begin
                    unit_start_d = sel_onehot;
                end
            end
            S_WAIT: begin
                wd_en = 1'b1;
                // A completion that lands on the expiry cycle still counts as a completion
                if (sel_done && !sel_busy) begin
                    next_pc_d = sel_npc;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else if (wd_expired) begin
                    timeout = 1'b1;
                end
            end
            S_TRAP: begin
                error_d    = 1'b1;
                err_code_d = ERR_ILLEGAL;
                next_pc_d  = pc_inc;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            unit_start_d = '0;
            error_d      = 1'b1;
            err_code_d   = ERR_TIMEOUT;
            next_pc_d    = pc_inc;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            next_pc_q    <= '0;
            unit_start_q <= '0;
            op_type_q    <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            dst_q        <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            next_pc_q    <= next_pc_d;
            unit_start_q <= unit_start_d;
            op_type_q    <= op_type_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            dst_q        <= dst_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fetch_en   = done_q;
    assign bus.error      = error_q;
    assign bus.err_code   = err_code_q;
    assign bus.next_pc    = next_pc_q;
    assign bus.unit_start = unit_start_q;
    assign bus.op_type    = op_type_q;
    assign bus.src1_addr  = src1_q;
    assign bus.src2_addr  = src2_q;
    assign bus.dst_addr   = dst_q;
    assign bus.pc         = pc_q;
    assign bus.imm        = imm_q;

endmodule

// File: tb/tb_instr_dispatch_controller.sv
// Directed and randomized transactions against a latency/outcome model of the dispatch stage;
// unselected units are driven with random busy/done/next_pc noise throughout.
module tb_instr_dispatch_controller;
    import instr_dispatch_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int PCW = 5;
    localparam int OPW = 5;
    localparam int NU  = 4;
    localparam int TO  = 8;
    localparam int IW  = 2 + OPW + 3 * AW + PCW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_dispatch_controller_if #(
        .DW(DW), .AW(AW), .PCW(PCW), .OPW(OPW), .NUM_UNITS(NU)
    ) bus ();

    instr_dispatch_controller #(
        .DW(DW), .AW(AW), .PCW(PCW), .OPW(OPW), .NUM_UNITS(NU), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // selected-unit model drives sel_*; every other unit is random noise
    logic [NU-1:0]     sel_mask   = '0;
    logic              sel_busy   = 1'b0;
    logic              sel_done   = 1'b0;
    logic [PCW-1:0]    sel_npc    = '0;
    logic [NU-1:0]     noise_busy = '0;
    logic [NU-1:0]     noise_done = '0;
    logic [NU*PCW-1:0] noise_npc  = '0;

    assign bus.unit_busy = (noise_busy & ~sel_mask) | (sel_busy ? sel_mask : '0);
    assign bus.unit_done = (noise_done & ~sel_mask) | (sel_done ? sel_mask : '0);

    always_comb begin
        bus.unit_next_pc = noise_npc;
        for (int u = 0; u < NU; u++) begin
            if (sel_mask[u]) bus.unit_next_pc[u*PCW +: PCW] = sel_npc;
        end
    end

    always @(negedge clk) begin
        noise_busy = NU'($urandom);
        noise_done = NU'($urandom);
        noise_npc  = (NU*PCW)'($urandom);
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outcome from the handshake rules: unit_start is visible one edge after acceptance,
    // the unit reacts d cycles after seeing it, stays busy len cycles, then pulses done.
    // Counting the start edge as edge 1, completion lands on edge 3+d+len; a trap on edge 2;
    // a timeout on edge TO+2, with completion winning a tie.
    task automatic run_txn(input string name, input logic [4:0] opc, input logic [4:0] pcv,
                           input int d, input int len, input logic [4:0] npc, input bit hold);
        logic [1:0]  ot;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] immv;
        bit          legal, trig, stray, seen;
        int          e_exp, cnt_exp, e, t, scount;
        logic [1:0]  code_exp;
        logic [4:0]  npc_exp;

        ot = 2'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        immv = $urandom;
        legal = (int'(opc) < NU);
        cnt_exp = (1 + d < TO) ? 1 + d : TO;
        if (!legal) begin
            e_exp = 2; cnt_exp = 0; code_exp = ERR_ILLEGAL; npc_exp = pcv + 5'd1;
        end else if (3 + d + len <= TO + 2) begin
            e_exp = 3 + d + len; code_exp = ERR_NONE; npc_exp = npc;
        end else begin
            e_exp = TO + 2; code_exp = ERR_TIMEOUT; npc_exp = pcv + 5'd1;
        end

        sel_mask  = legal ? (NU'(1) << opc) : '0;
        sel_npc   = npc;
        sel_busy  = 1'b0;
        sel_done  = 1'b0;
        bus.instr = {ot, opc, rd, rs1, rs2, pcv, immv};
        bus.start = 1'b1;

        e = 0; t = 0; scount = 0; trig = 1'b0; stray = 1'b0; seen = 1'b0;
        while (!seen && e < TO + 12) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e == 1) begin
                check({name, "/busy_set"},   64'(bus.busy),      64'(1));
                check({name, "/done_clr"},   64'(bus.done),      64'(0));
                check({name, "/fetch_clr"},  64'(bus.fetch_en),  64'(0));
                check({name, "/error_clr"},  64'(bus.error),     64'(0));
                check({name, "/code_clr"},   64'(bus.err_code),  64'(0));
                check({name, "/fields"},
                      64'({bus.op_type, bus.dst_addr, bus.src1_addr, bus.src2_addr, bus.pc}),
                      64'({ot, rd, rs1, rs2, pcv}));
                check({name, "/imm"},        64'(bus.imm),       64'(immv));
                if (hold) bus.instr = IW'({$urandom, $urandom});
                else      bus.start = 1'b0;
            end
            if (legal && (bus.unit_start & sel_mask) != '0) scount++;
            if ((bus.unit_start & ~sel_mask) != '0) stray = 1'b1;
            if (bus.done) begin
                seen = 1'b1;
            end else if (legal) begin
                if (!trig && (bus.unit_start & sel_mask) != '0) trig = 1'b1;
                if (trig) begin
                    sel_busy = (t >= d) && (t < d + len);
                    sel_done = (t == d + len);
                    t++;
                end
            end
        end
        sel_busy = 1'b0;
        sel_done = 1'b0;

        check({name, "/latency"},    64'(e),              64'(e_exp));
        check({name, "/done"},       64'(bus.done),       64'(1));
        check({name, "/fetch_en"},   64'(bus.fetch_en),   64'(1));
        check({name, "/busy_clr"},   64'(bus.busy),       64'(0));
        check({name, "/error"},      64'(bus.error),      64'(code_exp != ERR_NONE));
        check({name, "/err_code"},   64'(bus.err_code),   64'(code_exp));
        check({name, "/next_pc"},    64'(bus.next_pc),    64'(npc_exp));
        check({name, "/start_off"},  64'(bus.unit_start), 64'(0));
        check({name, "/start_cyc"},  64'(scount),         64'(cnt_exp));
        check({name, "/stray"},      64'(stray),          64'(0));
        check({name, "/dst_stable"}, 64'(bus.dst_addr),   64'(rd));
        $display("[TB] %s op=%0d pc=%0d edges=%0d err_code=%0d next_pc=%0d hold=%0d",
                 name, opc, pcv, e, bus.err_code, bus.next_pc, hold);

        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "/done_held"},    64'(bus.done),    64'(1));
            check({name, "/next_pc_held"}, 64'(bus.next_pc), 64'(npc_exp));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.instr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/busy",       64'(bus.busy),       64'(0));
        check("reset/done",       64'(bus.done),       64'(0));
        check("reset/fetch_en",   64'(bus.fetch_en),   64'(0));
        check("reset/error",      64'(bus.error),      64'(0));
        check("reset/err_code",   64'(bus.err_code),   64'(0));
        check("reset/next_pc",    64'(bus.next_pc),    64'(0));
        check("reset/unit_start", 64'(bus.unit_start), 64'(0));
        check("reset/fields",     64'({bus.op_type, bus.dst_addr, bus.src1_addr, bus.src2_addr, bus.pc, bus.imm}), 64'(0));
        rst = 1'b0;

        // ADD r3 = r1 + r2 held in WAIT, then reset
        sel_mask  = NU'(1) << ADD;
        bus.instr = {2'b00, 5'(ADD), 5'd3, 5'd1, 5'd2, 5'd4, 32'h0};
        bus.start = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rstwait/start_on", 64'(bus.unit_start), 64'(4'b0001));
        sel_busy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstwait/in_wait", 64'({bus.busy, bus.unit_start}), 64'({1'b1, 4'b0000}));
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        sel_busy = 1'b0;
        check("rstwait/busy",       64'(bus.busy),       64'(0));
        check("rstwait/done",       64'(bus.done),       64'(0));
        check("rstwait/unit_start", 64'(bus.unit_start), 64'(0));
        check("rstwait/next_pc",    64'(bus.next_pc),    64'(0));
        check("rstwait/dst",        64'(bus.dst_addr),   64'(0));
        $display("[TB] reset_mid_wait busy=%0d done=%0d next_pc=%0d", bus.busy, bus.done, bus.next_pc);

        run_txn("min_latency",  5'(ADD), 5'd10, 0, 1, 5'd11, 1'b0);
        run_txn("legal_div",    5'(DIV), 5'd7,  0, 3, 5'd8,  1'b0);
        run_txn("illegal",      5'd9,    5'd31, 0, 1, 5'd0,  1'b0);
        run_txn("timeout",      5'(MUL), 5'd12, 99, 1, 5'd0, 1'b0);
        run_txn("tie_complete", 5'(CMP), 5'd20, 2, 5, 5'd3,  1'b0);
        run_txn("late_timeout", 5'(CMP), 5'd21, 2, 6, 5'd3,  1'b0);
        run_txn("b2b_first",    5'(MUL), 5'd1,  1, 2, 5'd5,  1'b1);
        run_txn("b2b_second",   5'(ADD), 5'd2,  0, 2, 5'd6,  1'b1);
        run_txn("b2b_trap",     5'd17,   5'd3,  0, 1, 5'd0,  1'b0);
        run_txn("noise_unit0",  5'(ADD), 5'd9,  3, 2, 5'd30, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] ropc;
            ropc = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
            run_txn($sformatf("rand%0d", i), ropc, 5'($urandom), int'($urandom_range(0, 9)),
                    int'($urandom_range(1, 6)), 5'($urandom), 1'($urandom_range(0, 1)));
        end
        bus.start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("final/idle_busy", 64'(bus.busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
